// File: rtl/fft_spi_streamer.sv
// fft_spi_streamer: streams the 2^M result bins of the FFT result RAM to an
// external SPI master (mode 0, MSB first). The master's sck and cs_n are
// oversampled in the clk domain. The next bin is prefetched into next_reg so
// that consecutive words go out back-to-back with no gap.
//
// Result RAM interface: rd_en is a one-cycle strobe qualifying rd_addr, and
// rd_data holds that word in the cycle after the strobe. There is no
// back-pressure; rd_vld (rd_en delayed by one clk) marks the cycle in which
// rd_data may be captured.
module fft_spi_streamer #(
    parameter int M           = 9,
    parameter int WIDTH       = 32,
    parameter int MAG_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             rd_en,
    output logic [M-1:0]     rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             sck,
    input  logic             cs_n,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [1:0]       dbg_state
);

    localparam int H  = WIDTH / 2;
    localparam int OW = (MAG_MODE != 0) ? H : WIDTH;
    localparam int BW = $clog2(OW);
    localparam logic [M-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   fe;
    logic                   rd_vld;
    logic                   sel_seen;
    logic [OW-1:0]          shift_reg;
    logic [OW-1:0]          next_reg;
    logic [BW-1:0]          bit_cnt;
    logic [M-1:0]           word_cnt;

    // Convert a RAM word to the transmitted word. In magnitude mode the sum
    // |re|+|im| is formed one bit wider than a half word, so the most
    // negative value is represented exactly and overflow is visible in the
    // top bit, which saturates the result to all ones.
    function automatic logic [OW-1:0] conv(input logic [WIDTH-1:0] w);
        logic [H:0] re_x;
        logic [H:0] im_x;
        logic [H:0] re_a;
        logic [H:0] im_a;
        logic [H:0] sum;
        re_x = {w[WIDTH-1], w[WIDTH-1:H]};
        im_x = {w[H-1], w[H-1:0]};
        re_a = re_x[H] ? -re_x : re_x;
        im_a = im_x[H] ? -im_x : im_x;
        sum  = re_a + im_a;
        if (MAG_MODE == 0)
            conv = w[OW-1:0];
        else if (sum[H])
            conv = '1;
        else
            conv = OW'(sum[H-1:0]);
    endfunction

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign fe        = sck_d & ~sck_s;
    assign dbg_state = state;

    // Synchronise sck and cs_n into clk and keep one extra sck sample for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_d    <= sck_s;
        end
    end

    // Frame sequencer: first fetch, prefetch of following bins, shifting, done/abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_vld    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            sel_seen  <= 1'b0;
            shift_reg <= '0;
            next_reg  <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            rd_en  <= 1'b0;
            done   <= 1'b0;
            abort  <= 1'b0;
            rd_vld <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH0;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        sel_seen <= 1'b0;
                    end
                end
                FETCH0: begin
                    // Bin 0 is back: load it and start fetching bin 1 at once
                    if (rd_vld) begin
                        shift_reg <= conv(rd_data);
                        bit_cnt   <= '0;
                        rd_en     <= 1'b1;
                        rd_addr   <= M'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rd_vld)
                        next_reg <= conv(rd_data);
                    if (!cs_s)
                        sel_seen <= 1'b1;
                    // Only a deselect after the master has selected us ends
                    // the frame early; cs_n still high from before the frame
                    // is simply a master that has not started yet.
                    if (cs_s && sel_seen) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!cs_s && fe) begin
                        if (bit_cnt == BW'(OW - 1)) begin
                            bit_cnt <= '0;
                            if (word_cnt == LAST) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                shift_reg <= next_reg;
                                word_cnt  <= word_cnt + M'(1);
                                if (rd_addr != LAST) begin
                                    rd_en   <= 1'b1;
                                    rd_addr <= rd_addr + M'(1);
                                end
                            end
                        end else begin
                            shift_reg <= {shift_reg[OW-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive the current MSB while selected in a frame, otherwise hold sdo low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sdo <= 1'b0;
        else
            sdo <= (state == SHIFT && !cs_s) ? shift_reg[OW-1] : 1'b0;
    end

endmodule

// File: tb/tb_fft_spi_streamer.sv
// Bench for fft_spi_streamer: a full-word instance and a magnitude-mode
// instance share reset, sck and cs_n, each with its own start and RAM model.
// A behavioural SPI master clocks frames with random sck phase lengths and
// compares every received word against an expected queue built from the RAM
// contents.
module tb_fft_spi_streamer;

    localparam int W  = 32;
    localparam int M0 = 6;
    localparam int M1 = 3;
    localparam int N0 = 1 << M0;
    localparam int N1 = 1 << M1;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic sck    = 1'b0;
    logic cs_n   = 1'b1;

    logic          rd_en0, sdo0, busy0, done0, abort0;
    logic [M0-1:0] rd_addr0;
    logic [W-1:0]  rd_data0 = '0;
    logic [1:0]    dbg0;
    logic          rd_en1, sdo1, busy1, done1, abort1;
    logic [M1-1:0] rd_addr1;
    logic [W-1:0]  rd_data1 = '0;
    logic [1:0]    dbg1;

    logic [W-1:0] ram0 [N0];
    logic [W-1:0] ram1 [N1];
    logic [W-1:0] exp_q [$];
    int           rd_log0 [$];
    int           rd_log1 [$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt0 = 0, done_cnt1 = 0, abort_cnt0 = 0, abort_cnt1 = 0;
    logic busy_at_done0 = 1'b1;

    // clock
    always #5 clk = ~clk;

    fft_spi_streamer #(.M(M0), .WIDTH(W), .MAG_MODE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .sck(sck), .cs_n(cs_n), .sdo(sdo0), .busy(busy0),
        .done(done0), .abort(abort0), .dbg_state(dbg0)
    );

    fft_spi_streamer #(.M(M1), .WIDTH(W), .MAG_MODE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .sck(sck), .cs_n(cs_n), .sdo(sdo1), .busy(busy1),
        .done(done1), .abort(abort1), .dbg_state(dbg1)
    );

    // synchronous-read RAM models
    always @(posedge clk) begin
        if (rd_en0) rd_data0 <= ram0[rd_addr0];
        if (rd_en1) rd_data1 <= ram1[rd_addr1];
    end

    // monitors
    always @(negedge clk) begin
        if (rd_en0) rd_log0.push_back(int'(rd_addr0));
        if (rd_en1) rd_log1.push_back(int'(rd_addr1));
        if (done0) begin
            done_cnt0++;
            busy_at_done0 = busy0;
        end
        if (done1) done_cnt1++;
        if (abort0) abort_cnt0++;
        if (abort1) abort_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // |re|+|im| of the two signed 16-bit halves, capped at 16 bits
    function automatic logic [31:0] ref_mag(input logic [31:0] w);
        int re, im, s;
        re = int'(w[31:16]);
        im = int'(w[15:0]);
        if (re >= 32768) re = re - 65536;
        if (im >= 32768) im = im - 65536;
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        s = re + im;
        if (s > 65535) s = 65535;
        return 32'(s);
    endfunction

    // wait n clocks, optionally throwing stray start pulses at the busy DUT
    task automatic wait_clks(input int sel, input int n, input bit noise);
        repeat (n) begin
            @(negedge clk);
            if (noise) begin
                if (sel == 0) start0 = ($urandom_range(0, 30) == 0);
                else          start1 = ($urandom_range(0, 30) == 0);
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // start a frame and clock nbits out of it as the SPI master
    task automatic run_frame(input int sel, input int nbits, input int ow,
                             input int pre_tog, input bit cs_with_start);
        logic [31:0] rx;
        logic [31:0] mask;
        logic [31:0] exp;
        int          got_bits;
        rx       = '0;
        got_bits = 0;
        mask     = (ow == 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1);
        if (cs_with_start) begin
            cs_n = 1'b0;
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        cs_n = 1'b1;
        if (sel == 0) start0 = 1'b1;
        else          start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (pre_tog) begin
            sck = 1'b1;
            wait_clks(sel, 6, 1'b0);
            sck = 1'b0;
            wait_clks(sel, 6, 1'b0);
        end
        cs_n = 1'b0;
        wait_clks(sel, 8, 1'b0);
        check("busy_in_frame", 32'((sel == 0) ? busy0 : busy1), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            rx = {rx[30:0], (sel == 0) ? sdo0 : sdo1};
            sck = 1'b1;
            got_bits++;
            if (got_bits == ow) begin
                got_bits = 0;
                if (exp_q.size() == 0) begin
                    check("exp_empty", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("word", rx & mask, exp & mask);
                end
            end
            wait_clks(sel, $urandom_range(5, 8), (b < nbits - 1));
            sck = 1'b0;
            wait_clks(sel, $urandom_range(5, 8), (b < nbits - 1));
        end
        wait_clks(sel, 10, 1'b0);
    endtask

    int dc, ac;

    initial begin
        // reset held: toggling inputs must not move any output
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sck    = 1'($urandom_range(0, 1));
            start0 = 1'($urandom_range(0, 1));
            start1 = 1'($urandom_range(0, 1));
            #1;
            check("reset_outs", 32'({sdo0, busy0, done0, abort0, rd_en0,
                                     sdo1, busy1, done1, abort1, rd_en1}), 32'd0);
        end
        check("reset_addr", 32'(rd_addr0), 32'd0);
        start0 = 1'b0;
        start1 = 1'b0;
        sck    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // full frame, word k = {k, ~k}
        for (int k = 0; k < N0; k++) ram0[k] = {16'(k), ~16'(k)};
        for (int k = 0; k < N0; k++) exp_q.push_back(ram0[k]);
        rd_log0.delete();
        dc = done_cnt0;
        ac = abort_cnt0;
        run_frame(0, N0 * 32, 32, 0, 1'b0);
        check("frame_left", 32'(exp_q.size()), 32'd0);
        check("done_once", 32'(done_cnt0 - dc), 32'd1);
        check("busy_at_done", 32'(busy_at_done0), 32'd0);
        check("busy_after", 32'(busy0), 32'd0);
        check("rd_count", 32'(rd_log0.size()), 32'(N0));
        for (int i = 0; i < rd_log0.size() && i < N0; i++)
            check("rd_addr_seq", 32'(rd_log0[i]), 32'(i));
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_abort_idle", 32'(abort_cnt0 - ac), 32'd0);

        // magnitude mode, with sck noise under cs_n=1 and cs_n rising with start
        ram1[0] = 32'h8000_8000;
        ram1[1] = 32'hFFFF_0001;
        ram1[2] = 32'h7FFF_7FFF;
        for (int k = 3; k < N1; k++) ram1[k] = $urandom;
        exp_q.delete();
        for (int k = 0; k < N1; k++) exp_q.push_back(ref_mag(ram1[k]));
        rd_log1.delete();
        dc = done_cnt1;
        run_frame(1, N1 * 16, 16, 5, 1'b1);
        check("mag_left", 32'(exp_q.size()), 32'd0);
        check("mag_done", 32'(done_cnt1 - dc), 32'd1);
        check("mag_rd_count", 32'(rd_log1.size()), 32'(N1));
        for (int i = 0; i < rd_log1.size() && i < N1; i++)
            check("mag_rd_seq", 32'(rd_log1[i]), 32'(i));
        cs_n = 1'b1;
        repeat (10) @(negedge clk);

        // abort after bit 10 of word 3, random RAM contents
        for (int k = 0; k < N0; k++) ram0[k] = $urandom;
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(ram0[k]);
        dc = done_cnt0;
        ac = abort_cnt0;
        run_frame(0, 3 * 32 + 11, 32, 0, 1'b0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_pulse", 32'(abort_cnt0 - ac), 32'd1);
        check("abort_no_done", 32'(done_cnt0 - dc), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);

        // restart begins at word 0; then async reset in the middle of word 2
        exp_q.delete();
        for (int k = 0; k < 2; k++) exp_q.push_back(ram0[k]);
        run_frame(0, 2 * 32 + 5, 32, 0, 1'b0);
        check("restart_left", 32'(exp_q.size()), 32'd0);
        check("busy_pre_rst", 32'(busy0), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_outs", 32'({sdo0, busy0, done0, abort0, rd_en0}), 32'd0);
        check("rst_addr", 32'(rd_addr0), 32'd0);
        check("rst_state", 32'(dbg0), 32'd0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // after reset the next frame starts at bin 0 again
        exp_q.delete();
        exp_q.push_back(ram0[0]);
        ac = abort_cnt0;
        run_frame(0, 40, 32, 0, 1'b0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_left", 32'(exp_q.size()), 32'd0);
        check("post_rst_abort", 32'(abort_cnt0 - ac), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
